// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: the default bus width,
// the FSM state and owner encodings, and a counter-width helper.
package mem_port_arbiter_pkg;

    // The core's shared bus width. Address and data both default to it.
    localparam int DATA_WIDTH = 32;

    // A fetch always reads a whole instruction word.
    localparam logic [3:0] FETCH_BE = 4'hF;

    // Arbiter sequencing: choose a winner, present it, await the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Requester that owns the transaction currently in flight.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    // Bits needed to hold the values 0..max_val. Never less than one bit,
    // so degenerate settings (0 or negative) still give a legal vector.
    function automatic int cnt_width(input int max_val);
        if (max_val <= 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner select for the shared memory port, with the fetch starvation
// counter. Data normally wins, because a stalled load/store holds up the
// pipeline. Fetch is forced through once it has lost MAX_STARVE
// arbitrations in a row.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int STARVE_W   = cnt_width(MAX_STARVE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_arb_en,
    input  logic                i_if_req,
    input  logic                i_d_req,
    output logic                o_if_win,
    output logic                o_d_win,
    output logic [STARVE_W-1:0] o_starve_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_force_fetch;

    // Combinational winner select. A win is only reported while arbitration is enabled.
    always_comb begin
        w_force_fetch = i_if_req && (r_starve_cnt == STARVE_MAX);
        o_d_win       = i_arb_en && i_d_req && !w_force_fetch;
        o_if_win      = i_arb_en && i_if_req && !o_d_win;
    end

    // Count fetch losses. The count saturates, and any fetch win clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (o_if_win) begin
            r_starve_cnt <= '0;
        end else if (o_d_win && i_if_req && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    assign o_starve_cnt = r_starve_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// Only one transaction is in flight at a time. The response goes back to
// the requester that owns the transaction. A fetch killed by a branch is
// consumed silently, and a memory that never answers is reported on err.
//
// Handshake rules:
//   - if_req/d_req are held with stable fields until the matching gnt.
//   - gnt is a one-cycle acceptance, given only while the FSM is IDLE.
//   - mem_req stays high with stable mem_* fields until mem_ready.
//   - mem_rvalid is a one-cycle response and counts only after mem_ready.
//     It may arrive in the same cycle as mem_ready.
//   - if_rvalid/d_rvalid are one-cycle pulses. The matching rdata equals
//     mem_rdata during the pulse and holds that value afterwards.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DATA_WIDTH,
    parameter int DATA_W     = DATA_WIDTH,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    // fetch requester
    input  logic                               if_req,
    input  logic [ADDR_W-1:0]                  if_addr,
    input  logic                               if_kill,
    output logic                               if_gnt,
    output logic                               if_rvalid,
    output logic [DATA_W-1:0]                  if_rdata,
    // load/store requester
    input  logic                               d_req,
    input  logic                               d_we,
    input  logic [ADDR_W-1:0]                  d_addr,
    input  logic [DATA_W-1:0]                  d_wdata,
    input  logic [3:0]                         d_be,
    output logic                               d_gnt,
    output logic                               d_rvalid,
    output logic [DATA_W-1:0]                  d_rdata,
    // memory side
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    output logic [3:0]                         mem_be,
    input  logic                               mem_ready,
    input  logic                               mem_rvalid,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic                               err,
    // observation of internal state
    output logic [1:0]                         dbg_state,
    output logic [cnt_width(MAX_STARVE)-1:0]   dbg_starve
);

    localparam int STARVE_W = cnt_width(MAX_STARVE);
    // tmo_cnt only needs to reach TIMEOUT-1 before the transaction is aborted.
    localparam int TMO_W = cnt_width(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              r_owner;
    logic                r_kill;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [3:0]          r_mem_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_arb_en;
    logic                w_if_win;
    logic                w_d_win;
    logic [STARVE_W-1:0] w_starve_cnt;
    logic                w_mem_req;
    logic                w_complete;
    logic                w_timeout;
    logic                w_kill_now;
    logic                w_if_rvalid;
    logic                w_d_rvalid;

    // Arbitrate only in IDLE. It is suppressed while reset is high, so
    // nothing can be granted during reset.
    assign w_arb_en = (r_state == ST_IDLE) && !reset;

    mem_arb_prio #(
        .MAX_STARVE (MAX_STARVE),
        .STARVE_W   (STARVE_W)
    ) u_prio (
        .clk          (clk),
        .reset        (reset),
        .i_arb_en     (w_arb_en),
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .o_if_win     (w_if_win),
        .o_d_win      (w_d_win),
        .o_starve_cnt (w_starve_cnt)
    );

    // FSM next state, and detection of the completion and timeout events.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_if_win || w_d_win) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Route the response to its owner. A kill seen in the completing cycle
    // suppresses the response just as an earlier, latched kill does.
    always_comb begin
        w_kill_now  = r_kill || (if_kill && (r_owner == OWN_FETCH));
        w_if_rvalid = w_complete && !reset && (r_owner == OWN_FETCH) && !w_kill_now;
        w_d_rvalid  = w_complete && !reset && (r_owner == OWN_DATA);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request into the memory-side registers and record its owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_NONE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_d_win) begin
            r_owner     <= OWN_DATA;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_be    <= d_be;
        end else if (w_if_win) begin
            r_owner     <= OWN_FETCH;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= FETCH_BE;
        end else if ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) begin
            r_owner     <= OWN_NONE;
        end
    end

    // Sticky kill for the fetch in flight. It is dropped when the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kill <= 1'b0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_kill <= 1'b0;
        end else if ((r_state != ST_IDLE) && (r_owner == OWN_FETCH) && if_kill) begin
            r_kill <= 1'b1;
        end
    end

    // Response timeout counter. It restarts at acceptance and runs through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_REQ) && mem_ready) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Keep the last delivered word for each requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_rvalid) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt     = w_if_win;
    assign d_gnt      = w_d_win;
    assign if_rvalid  = w_if_rvalid;
    assign d_rvalid   = w_d_rvalid;
    assign if_rdata   = w_if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata    = w_d_rvalid ? mem_rdata : r_d_rdata;
    assign mem_req    = w_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign err        = w_timeout && !reset;
    assign dbg_state  = r_state;
    assign dbg_starve = w_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A table of per-cycle vectors covers the
// fetch, store and kill flows. Hand-written sequences cover fetch
// starvation, the response timeout and reset during a transaction.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          if_req, if_kill, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_be;
  logic          mem_req, mem_we, mem_ready, mem_rvalid, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_starve;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // ---------------- vector record ----------------
  typedef struct packed {
    logic          ifr;
    logic [31:0]   ia;
    logic          ik;
    logic          dr;
    logic          dwe;
    logic [31:0]   da;
    logic [31:0]   dwd;
    logic [3:0]    dbe;
    logic          rdy;
    logic          rv;
    logic [31:0]   rd;
    logic          e_ig;
    logic          e_dg;
    logic          e_mreq;
    logic          e_mwe;
    logic [31:0]   e_maddr;
    logic [31:0]   e_mwd;
    logic [3:0]    e_mbe;
    logic          e_irv;
    logic          e_drv;
    logic [31:0]   e_rdata;
    logic          e_err;
    logic [1:0]    e_st;
  } vec_t;

  vec_t vt[$];
  vec_t v;
  int   n_chk;
  int   n_fail;
  int   exp_starve;
  logic fw;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_in(input vec_t x);
    if_req     = x.ifr;
    if_addr    = x.ia;
    if_kill    = x.ik;
    d_req      = x.dr;
    d_we       = x.dwe;
    d_addr     = x.da;
    d_wdata    = x.dwd;
    d_be       = x.dbe;
    mem_ready  = x.rdy;
    mem_rvalid = x.rv;
    mem_rdata  = x.rd;
  endtask

  task automatic check_row(input int i, input vec_t e);
    chk($sformatf("r%0d if_gnt", i), {31'd0, if_gnt}, {31'd0, e.e_ig});
    chk($sformatf("r%0d d_gnt", i), {31'd0, d_gnt}, {31'd0, e.e_dg});
    chk($sformatf("r%0d mem_req", i), {31'd0, mem_req}, {31'd0, e.e_mreq});
    chk($sformatf("r%0d if_rvalid", i), {31'd0, if_rvalid}, {31'd0, e.e_irv});
    chk($sformatf("r%0d d_rvalid", i), {31'd0, d_rvalid}, {31'd0, e.e_drv});
    chk($sformatf("r%0d err", i), {31'd0, err}, {31'd0, e.e_err});
    chk($sformatf("r%0d state", i), {30'd0, dbg_state}, {30'd0, e.e_st});
    if (e.e_mreq) begin
      chk($sformatf("r%0d mem_we", i), {31'd0, mem_we}, {31'd0, e.e_mwe});
      chk($sformatf("r%0d mem_addr", i), mem_addr, e.e_maddr);
      chk($sformatf("r%0d mem_wdata", i), mem_wdata, e.e_mwd);
      chk($sformatf("r%0d mem_be", i), {28'd0, mem_be}, {28'd0, e.e_mbe});
    end
    if (e.e_irv) chk($sformatf("r%0d if_rdata", i), if_rdata, e.e_rdata);
    if (e.e_drv) chk($sformatf("r%0d d_rdata", i), d_rdata, e.e_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " if_gnt"}, {31'd0, if_gnt}, 32'd0);
    chk({tag, " d_gnt"}, {31'd0, d_gnt}, 32'd0);
    chk({tag, " if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, " d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, " if_rdata"}, if_rdata, 32'd0);
    chk({tag, " d_rdata"}, d_rdata, 32'd0);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " starve"}, {29'd0, dbg_starve}, 32'd0);
  endtask

  // One cycle: drive at negedge, sample 2 time units later.
  task automatic step(input vec_t x);
    @(negedge clk);
    apply_in(x);
    #2;
  endtask

  // ---------------- main ----------------
  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    v      = '0;
    apply_in(v);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check_all_zero("reset");
    chk("reset state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    // ---- Fetch only. The kill in IDLE must have no effect. Ready at c1, rvalid at c3.
    v = '0; v.ifr = 1; v.ia = 32'h10; v.ik = 1; v.e_ig = 1; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.rdy = 1; v.e_mreq = 1; v.e_maddr = 32'h10; v.e_mbe = 4'hF; v.e_st = ST_REQ; vt.push_back(v);
    v = '0; v.e_st = ST_WAIT; vt.push_back(v);
    v = '0; v.rv = 1; v.rd = 32'h00A00093; v.e_irv = 1; v.e_rdata = 32'h00A00093; v.e_st = ST_WAIT; vt.push_back(v);
    v = '0; v.e_st = ST_IDLE; vt.push_back(v);
    // ---- Store and fetch together: data first, then fetch.
    v = '0; v.ifr = 1; v.ia = 32'h20; v.dr = 1; v.dwe = 1; v.da = 32'h100; v.dwd = 32'hDEADBEEF; v.dbe = 4'hF;
    v.e_dg = 1; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.ifr = 1; v.ia = 32'h20; v.rdy = 1; v.rv = 1; v.rd = 32'h0000ACE0;
    v.e_mreq = 1; v.e_mwe = 1; v.e_maddr = 32'h100; v.e_mwd = 32'hDEADBEEF; v.e_mbe = 4'hF;
    v.e_drv = 1; v.e_rdata = 32'h0000ACE0; v.e_st = ST_REQ; vt.push_back(v);
    v = '0; v.ifr = 1; v.ia = 32'h20; v.e_ig = 1; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.rdy = 1; v.e_mreq = 1; v.e_maddr = 32'h20; v.e_mbe = 4'hF; v.e_st = ST_REQ; vt.push_back(v);
    v = '0; v.rv = 1; v.rd = 32'h13; v.e_irv = 1; v.e_rdata = 32'h13; v.e_st = ST_WAIT; vt.push_back(v);
    v = '0; v.e_st = ST_IDLE; vt.push_back(v);
    // ---- A fetch killed during WAIT is dropped. The next fetch is delivered normally.
    v = '0; v.ifr = 1; v.ia = 32'h40; v.e_ig = 1; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.rdy = 1; v.e_mreq = 1; v.e_maddr = 32'h40; v.e_mbe = 4'hF; v.e_st = ST_REQ; vt.push_back(v);
    v = '0; v.ik = 1; v.e_st = ST_WAIT; vt.push_back(v);
    v = '0; v.rv = 1; v.rd = 32'h13; v.e_st = ST_WAIT; vt.push_back(v);
    v = '0; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.ifr = 1; v.ia = 32'h44; v.e_ig = 1; v.e_st = ST_IDLE; vt.push_back(v);
    v = '0; v.rdy = 1; v.rv = 1; v.rd = 32'h93; v.e_mreq = 1; v.e_maddr = 32'h44; v.e_mbe = 4'hF;
    v.e_irv = 1; v.e_rdata = 32'h93; v.e_st = ST_REQ; vt.push_back(v);
    v = '0; v.e_st = ST_IDLE; vt.push_back(v);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i]);
      check_row(i, vt[i]);
    end

    // ---- Starvation: both requesters held, zero-wait memory.
    exp_starve = 0;
    for (int a = 0; a < 6; a++) begin
      fw = (exp_starve == 4);
      v = '0; v.ifr = 1; v.ia = 32'h80; v.dr = 1; v.da = 32'h200; v.rdy = 1; v.rv = 1; v.rd = 32'h1000 + a;
      step(v);
      chk($sformatf("starve a%0d cnt", a), {29'd0, dbg_starve}, exp_starve);
      chk($sformatf("starve a%0d if_gnt", a), {31'd0, if_gnt}, {31'd0, fw});
      chk($sformatf("starve a%0d d_gnt", a), {31'd0, d_gnt}, {31'd0, !fw});
      step(v);
      chk($sformatf("starve a%0d mem_addr", a), mem_addr, fw ? 32'h80 : 32'h200);
      chk($sformatf("starve a%0d if_rvalid", a), {31'd0, if_rvalid}, {31'd0, fw});
      chk($sformatf("starve a%0d d_rvalid", a), {31'd0, d_rvalid}, {31'd0, !fw});
      if (fw) exp_starve = 0;
      else if (exp_starve < 4) exp_starve++;
    end

    // ---- Timeout: no response. err must fire 8 cycles after mem_ready.
    v = '0; v.ifr = 1; v.ia = 32'h300; step(v);
    chk("tmo if_gnt", {31'd0, if_gnt}, 32'd1);
    v = '0; v.rdy = 1; step(v);
    chk("tmo mem_req", {31'd0, mem_req}, 32'd1);
    for (int k = 2; k <= 9; k++) begin
      v = '0; step(v);
      chk($sformatf("tmo c%0d err", k), {31'd0, err}, {31'd0, (k == 9)});
      chk($sformatf("tmo c%0d if_rvalid", k), {31'd0, if_rvalid}, 32'd0);
      chk($sformatf("tmo c%0d state", k), {30'd0, dbg_state}, {30'd0, ST_WAIT});
    end
    v = '0; v.dr = 1; v.da = 32'h304; v.dbe = 4'h3; step(v);
    chk("tmo after err", {31'd0, err}, 32'd0);
    chk("tmo after state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("tmo after d_gnt", {31'd0, d_gnt}, 32'd1);
    v = '0; v.rdy = 1; v.rv = 1; v.rd = 32'h55; step(v);
    chk("tmo next mem_be", {28'd0, mem_be}, 32'h3);
    chk("tmo next d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("tmo next d_rdata", d_rdata, 32'h55);

    // ---- Reset during WAIT, then a stray response.
    v = '0; v.ifr = 1; v.ia = 32'h400; step(v);
    chk("rst if_gnt", {31'd0, if_gnt}, 32'd1);
    v = '0; step(v);
    chk("rst stall mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst stall state", {30'd0, dbg_state}, {30'd0, ST_REQ});
    v = '0; v.rdy = 1; step(v);
    v = '0; step(v);
    chk("rst pre state", {30'd0, dbg_state}, {30'd0, ST_WAIT});
    @(negedge clk);
    reset = 1'b1;
    v = '0; apply_in(v);
    #2;
    chk("rst hi if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst hi err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v = '0; v.rv = 1; v.rd = 32'hBAD; apply_in(v);
    #2;
    check_all_zero("rst stray");
    chk("rst stray state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    v = '0; step(v);
    check_all_zero("rst after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester and the load/store (data) requester.
- Sits between the fetch/memory stages and the memory/bus interface.
- Allows one outstanding transaction at a time and sequences request, accept and response.
- Returns responses to the owning requester, drops fetches killed by a branch, and reports timeouts.

Parameters:
- ADDR_W, 32, address width (equals the shared DATA_WIDTH).
- DATA_W, 32, data width.
- MAX_STARVE, 4, consecutive fetch losses before fetch is forced to win.
- TIMEOUT, 255, cycles to wait for mem_rvalid before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address (PC)
- if_kill  in  1  discard the pending fetch response (branch taken)
- if_gnt  out  1  fetch request accepted by the arbiter
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  instruction word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid or store acknowledge (pulse)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response (reads and writes)
- mem_rdata  in  DATA_W  read data
- err  out  1  timeout pulse

Behaviour:
- Reset: synchronous, active-high; clock clk. Reset forces FSM=IDLE, owner=NONE, and clears starve_cnt and tmo_cnt. All outputs read 0 in the cycle after reset.
- Reset mid-transaction abandons the transaction: mem_req drops, and a later stray mem_rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE arbitration (combinational):
  - Data wins when d_req, unless if_req and starve_cnt==MAX_STARVE; then fetch wins.
  - The winner's gnt is high for exactly this cycle.
  - The request is latched into the mem_* registers; owner is set; next state is REQ.
  - No request: stay in IDLE.
- starve_cnt: increments when data wins while if_req=1; clears when fetch wins; saturates at MAX_STARVE.
- REQ: mem_req=1 with stable mem_* fields.
  - On mem_ready: go to WAIT and load tmo_cnt=0.
  - If mem_ready and mem_rvalid arrive in the same cycle, complete immediately (see WAIT response) and go to IDLE.
- WAIT: mem_req=0.
  - On mem_rvalid: pulse the owner's rvalid, drive rdata=mem_rdata, go to IDLE.
  - tmo_cnt increments each cycle.
  - If TIMEOUT>0 and tmo_cnt==TIMEOUT-1 with no mem_rvalid: pulse err, pulse no rvalid, go to IDLE.
- if_kill:
  - Sampled in REQ and WAIT while owner=FETCH; sets a sticky kill flag.
  - The completing response is consumed but if_rvalid stays 0.
  - The flag clears on return to IDLE.
  - if_kill in IDLE has no effect.
- Latency: request seen in IDLE at cycle 0 → gnt at cycle 0 → mem_req at cycle 1. With a zero-wait memory (mem_ready and mem_rvalid at cycle 1), rvalid is at cycle 1 and the next grant is possible at cycle 2.
- Data outputs: if_rdata and d_rdata are registered only on their valid pulse and hold their value otherwise.
- Requesters must keep req and fields stable until gnt. A req dropped before gnt is simply not granted.

Decomposition:
- Shared package/header: DATA_WIDTH, the FSM state encoding (IDLE/REQ/WAIT), and the owner encoding (NONE/FETCH/DATA).
- One natural sub-module: mem_arb_prio, the combinational winner select plus the starve_cnt register.

Test Plan:
- Fetch only, if_addr=0x00000010, memory ready at cycle 1 and rvalid at cycle 3 with 0x00A00093 → if_gnt at c0, mem_req c1, if_rvalid c3 with if_rdata=0x00A00093, d_rvalid never asserted.
- if_req and d_req together, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF → data granted first with mem_we=1; after d_rvalid, fetch is granted next.
- d_req held continuously with if_req held → fetch is granted on the 5th arbitration (MAX_STARVE=4); starve_cnt returns to 0.
- Fetch granted, if_kill pulsed during WAIT, rvalid returns 0x13 → if_rvalid stays 0; the FSM is in IDLE the next cycle.
- Fetch granted, mem_rvalid never arrives, TIMEOUT=8 → err pulses exactly once 8 cycles after mem_ready; FSM goes to IDLE; the next request is served.
- Reset asserted during WAIT, then stray mem_rvalid → all outputs 0; no rvalid or err pulse.
